// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM state
// encoding and memory-port owner codes.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic MEM_SEL_INSTR = 1'b0;
  localparam logic MEM_SEL_DATA  = 1'b1;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection: the load in EX writes a register that the
// instruction in ID reads. x0 never creates a dependency.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic [AW-1:0] ex_rd,
  input  logic          ex_mem_read,
  output logic          hz
);

  logic rd_nonzero_s;
  logic rd_match_s;

  assign rd_nonzero_s = (ex_rd != {AW{1'b0}});
  assign rd_match_s   = (ex_rd == id_rs1) | (ex_rd == id_rs2);
  assign hz           = ex_mem_read & rd_nonzero_s & rd_match_s;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: pipeline-register load/flush generation,
// unified-memory time multiplexing and stall/flush event counting.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int AW         = 5,
  parameter bit SHARED_MEM = 1'b1,
  parameter int CW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic [AW-1:0] ex_rd,
  input  logic          ex_mem_read,
  input  logic          mem_branch_taken,
  input  logic          wb_halt,
  output logic          pc_load,
  output logic          ifid_load,
  output logic          idex_load,
  output logic          exmem_load,
  output logic          memwb_load,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic          exmem_flush,
  output logic          mem_sel,
  output logic          halted,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_r;
  state_t        state_s;
  logic          phase_r;
  logic          phase_s;
  logic          adv_s;
  logic          hz_s;
  logic          stall_ev_s;
  logic          flush_ev_s;
  logic          halted_r;
  logic [CW-1:0] stall_cnt_r;
  logic [CW-1:0] flush_cnt_r;

  hazard_detect #(.AW(AW)) u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .hz          (hz_s)
  );

  // Split memories advance every cycle, so the phase is pinned to the advance slot.
  assign phase_s = SHARED_MEM ? phase_r : 1'b1;
  assign adv_s   = (state_r == ST_RUN) & phase_s;
  assign mem_sel = SHARED_MEM ? (phase_s ? MEM_SEL_INSTR : MEM_SEL_DATA) : MEM_SEL_INSTR;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_INIT: state_s = ST_RUN;
      ST_RUN: begin
        if (adv_s && wb_halt) begin
          state_s = ST_HALT;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_HALT: state_s = ST_HALT;
      default: state_s = ST_INIT;
    endcase
  end

  // FSM outputs: loads, flushes and counter events, by rule priority
  always_comb begin
    pc_load     = 1'b0;
    ifid_load   = 1'b0;
    idex_load   = 1'b0;
    exmem_load  = 1'b0;
    memwb_load  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    stall_ev_s  = 1'b0;
    flush_ev_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (!adv_s || wb_halt) begin
          pc_load = 1'b0;
        end else if (mem_branch_taken) begin
          {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = 5'b11111;
          {ifid_flush, idex_flush, exmem_flush}                   = 3'b111;
          flush_ev_s = 1'b1;
        end else if (hz_s) begin
          {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = 5'b00111;
          idex_flush = 1'b1;
          stall_ev_s = 1'b1;
        end else begin
          {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = 5'b11111;
        end
      end
      default: begin
        pc_load = 1'b0;
      end
    endcase
  end

  // Fetch/data slot phase; the halting edge still toggles since it is taken from RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN:  phase_r <= ~phase_r;
        ST_HALT: phase_r <= phase_r;
        default: phase_r <= 1'b0;
      endcase
    end
  end

  // Registered halt indication
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_r <= 1'b0;
    end else begin
      halted_r <= (state_s == ST_HALT);
    end
  end

  // Saturating stall/flush event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CW{1'b0}};
      flush_cnt_r <= {CW{1'b0}};
    end else begin
      if (stall_ev_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (flush_ev_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

  assign halted    = halted_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl (shared memory, 2-bit counters):
// the driver queues hand-computed outputs per cycle, a negedge monitor checks them.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs1 = 5'd0;
  logic [4:0] id_rs2 = 5'd0;
  logic [4:0] ex_rd = 5'd0;
  logic       ex_mem_read = 1'b0;
  logic       mem_branch_taken = 1'b0;
  logic       wb_halt = 1'b0;
  logic       pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  logic       ifid_flush, idex_flush, exmem_flush;
  logic       mem_sel, halted;
  logic [1:0] stall_cnt, flush_cnt;

  typedef struct {
    logic [13:0] v;
    int          n;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  pipe_ctrl #(.AW(5), .SHARED_MEM(1'b1), .CW(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .ex_rd            (ex_rd),
    .ex_mem_read      (ex_mem_read),
    .mem_branch_taken (mem_branch_taken),
    .wb_halt          (wb_halt),
    .pc_load          (pc_load),
    .ifid_load        (ifid_load),
    .idex_load        (idex_load),
    .exmem_load       (exmem_load),
    .memwb_load       (memwb_load),
    .ifid_flush       (ifid_flush),
    .idex_flush       (idex_flush),
    .exmem_flush      (exmem_flush),
    .mem_sel          (mem_sel),
    .halted           (halted),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  always #5 clk = ~clk;

  // One cycle: drive inputs just after the rising edge and queue the expected outputs.
  // Layout: loads{pc,ifid,idex,exmem,memwb} flushes{ifid,idex,exmem} mem_sel halted stall_cnt flush_cnt
  task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic mr, input logic br, input logic wh,
                     input logic [4:0] el, input logic [2:0] ef, input logic ems,
                     input logic eh, input logic [1:0] esc, input logic [1:0] efc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
    ex_mem_read = mr; mem_branch_taken = br; wb_halt = wh;
    e.v = {el, ef, ems, eh, esc, efc};
    e.n = cyc_n;
    exp_q.push_back(e);
    cyc_n++;
  endtask

  // Monitor: compare every presented cycle against the scoreboard head
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [13:0] act;
      e   = exp_q.pop_front();
      act = {pc_load, ifid_load, idex_load, exmem_load, memwb_load,
             ifid_flush, idex_flush, exmem_flush, mem_sel, halted, stall_cnt, flush_cnt};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL outs@c%0d: got %b required %b", e.n, act, e.v);
      end
    end
  end

  initial begin
    // reset held, then INIT, RUN phase 0, first advance
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd0, 2'd0);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd0, 2'd0);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd0, 2'd0);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd0, 2'd0);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11111, 3'b000, 1'b0, 1'b0, 2'd0, 2'd0);
    // load-use: ignored on the data slot, stalls on the advance slot
    cyc(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd0, 2'd0);
    cyc(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 5'b00111, 3'b010, 1'b0, 1'b0, 2'd0, 2'd0);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd1, 2'd0);
    // ex_rd = x0 never stalls
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'b11111, 3'b000, 1'b0, 1'b0, 2'd1, 2'd0);
    // branch together with hazard: branch wins
    cyc(1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd1, 2'd0);
    cyc(1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 5'b11111, 3'b111, 1'b0, 1'b0, 2'd1, 2'd0);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd1, 2'd1);
    // back-to-back stalls drive stall_cnt into saturation at 3
    cyc(1'b1, 5'd3, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0, 5'b00111, 3'b010, 1'b0, 1'b0, 2'd1, 2'd1);
    cyc(1'b1, 5'd3, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd2, 2'd1);
    cyc(1'b1, 5'd3, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0, 5'b00111, 3'b010, 1'b0, 1'b0, 2'd2, 2'd1);
    cyc(1'b1, 5'd3, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd3, 2'd1);
    cyc(1'b1, 5'd3, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0, 5'b00111, 3'b010, 1'b0, 1'b0, 2'd3, 2'd1);
    cyc(1'b1, 5'd3, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd3, 2'd1);
    cyc(1'b1, 5'd3, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0, 5'b00111, 3'b010, 1'b0, 1'b0, 2'd3, 2'd1);
    cyc(1'b1, 5'd3, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd3, 2'd1);
    cyc(1'b1, 5'd3, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0, 5'b00111, 3'b010, 1'b0, 1'b0, 2'd3, 2'd1);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd3, 2'd1);
    // halt beats branch and hazard; phase toggles once more on the halting edge
    cyc(1'b1, 5'd3, 5'd9, 5'd3, 1'b1, 1'b1, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0, 2'd3, 2'd1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 5'd3, 5'd9, 5'd3, 1'b1, 1'b1, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b1, 2'd3, 2'd1);
    end
    // reset out of HALT and restart; branch to make flush_cnt nonzero
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd0, 2'd0);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd0, 2'd0);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd0, 2'd0);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b11111, 3'b111, 1'b0, 1'b0, 2'd0, 2'd0);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd0, 2'd1);
    // asynchronous reset between edges on an advance cycle
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd0, 2'd0);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd0, 2'd0);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b1, 1'b0, 2'd0, 2'd0);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11111, 3'b000, 1'b0, 1'b0, 2'd0, 2'd0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage RV32 core. It generates the load and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, which are plain load-enable registers. It also time-multiplexes the single-ported unified memory between instruction fetch and data access. The block sits beside the datapath. It takes hazard information from the ID/EX/MEM stages and owns every pipeline-register `load` input and the memory port select.

## Interface
- `AW`, default 5: register-file address width.
- `SHARED_MEM`, default 1:
  - 1: single-ported memory, and the pipeline advances every 2nd cycle.
  - 0: split memories, and the pipeline advances every cycle.
- `CW`, default 16: width of the stall/flush event counters.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `id_rs1`, `id_rs2`  in  AW  source registers of the instruction in ID.
- `ex_rd`  in  AW  destination register of the instruction in EX.
- `ex_mem_read`  in  1  the instruction in EX is a load.
- `mem_branch_taken`  in  1  a branch/jump resolved taken in MEM.
- `wb_halt`  in  1  ECALL/EBREAK/FENCE reached WB.
- `pc_load`, `ifid_load`, `idex_load`, `exmem_load`, `memwb_load`  out  1  load enables for the pipeline registers.
- `ifid_flush`, `idex_flush`, `exmem_flush`  out  1  replace the next register contents with a NOP/bubble.
- `mem_sel`  out  1  memory port owner: 0 = instruction fetch, 1 = data access.
- `halted`  out  1  the core is stopped.
- `stall_cnt`, `flush_cnt`  out  CW  saturating event counters.

## Operation
- State machine, with states INIT, RUN and HALT.
  - Reset enters INIT.
  - INIT → RUN after exactly one cycle.
  - RUN → HALT on an advance cycle with `wb_halt`=1.
  - HALT is left only by reset.
- `phase` flip-flop (SHARED_MEM=1):
  - Cleared to 0 by reset and held at 0 in INIT.
  - Toggles every cycle in RUN.
  - Frozen in HALT.
  - With SHARED_MEM=0, `phase` is constant 1.
- Memory port:
  - SHARED_MEM=1: `mem_sel` = ~`phase`. Phase 0 is the data slot for the MEM stage; phase 1 is the fetch slot.
  - SHARED_MEM=0: `mem_sel`=0.
- An advance cycle is any cycle in RUN with `phase`=1. All loads are 0 on non-advance cycles and in INIT/HALT.
- Hazard: `hz` = `ex_mem_read` & (`ex_rd`≠0) & ((`ex_rd`==`id_rs1`) | (`ex_rd`==`id_rs2`)).
- On an advance cycle, the first matching rule below applies:
  1. `wb_halt`: all loads 0 and no flushes. Enter HALT.
  2. `mem_branch_taken`: all loads 1, and `ifid_flush`=`idex_flush`=`exmem_flush`=1. This overrides `hz`.
  3. `hz`: `pc_load`=`ifid_load`=0, the other loads 1, `idex_flush`=1.
  4. Otherwise: all loads 1 and no flushes.
- Flushes are asserted only together with the matching load. Flush outside an advance cycle is 0.
- Counters:
  - `stall_cnt` increments on each rule-3 cycle.
  - `flush_cnt` increments on each rule-2 cycle.
  - Both saturate at 2^CW−1, are cleared by reset, and hold in HALT.

## Timing
- Reset values (while `rst`=0 and immediately after):
  - All loads and flushes = 0.
  - `mem_sel`=0 when SHARED_MEM=0; `mem_sel`=1 when SHARED_MEM=1, following `phase`=0.
  - `halted`=0, counters = 0, state = INIT, `phase`=0.
- Loads, flushes and `mem_sel` are combinational from the registered state/`phase` and the current inputs. There are no additional registers on these outputs.
- `halted` is registered: it is 1 from the cycle after the halting advance edge.
- First advance:
  - SHARED_MEM=1: cycle 2 after reset release. Cycle 0 is INIT, cycle 1 is RUN with `phase`=0, cycle 2 is RUN with `phase`=1.
  - SHARED_MEM=0: cycle 1.
- A load-use stall costs exactly one advance slot: 2 clocks with SHARED_MEM=1, 1 clock with SHARED_MEM=0.
- A taken branch costs 3 bubbles.
- Simultaneous `hz` and `mem_branch_taken`: the branch wins, and `stall_cnt` is unchanged.
- Inputs sampled on non-advance cycles have no effect.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronously).

## Structure
- Shared package `pipe_pkg`: state encoding (INIT=2'd0, RUN=2'd1, HALT=2'd2) and the MEM_SEL_INSTR/MEM_SEL_DATA constants.
- One sub-module, `hazard_detect`: combinational `hz` from `id_rs1`, `id_rs2`, `ex_rd` and `ex_mem_read`, parameterised by AW.
- The FSM, phase logic and counters live in `pipe_ctrl`.

## Test plan
- Reset release with SHARED_MEM=1 → loads 0 on cycles 0–1; all loads 1 on cycle 2; `mem_sel` sequence 1,1,0,1,0.
- Load-use case: `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5 on an advance cycle → `pc_load`=`ifid_load`=0, `idex_flush`=1, `stall_cnt`=1. With `ex_rd`=0 the same stimulus gives no stall.
- `mem_branch_taken`=1 together with `hz`=1 → all loads 1, three flushes 1, `flush_cnt`=1, `stall_cnt`=0.
- `wb_halt`=1 on an advance cycle → all loads 0 from then on; `halted`=1 on the next cycle; `phase` and the counters stay frozen for 10 cycles.
- Saturation with CW=2 and 5 consecutive stalls → `stall_cnt` holds at 3.
- `rst` driven low between clock edges mid-run → outputs reach their reset values before the next edge; the block restarts in INIT.
